uart_frame_scheduler: RTL and testbench

- Shares the single framed-UART sender (1032-byte frames: 6-byte header, 1024 payload, 2-byte trailer) among NUM_REQ lidar data producers.
- Counts the frames each producer announces and grants the sender one complete frame at a time, in round-robin order.
- Issues a start pulse with a channel index, then waits for the sender's completion pulse.
- A watchdog aborts any frame that stalls.

---
 rtl/uart_sched_pkg.sv | 8 +
 rtl/uart_frame_scheduler_req.sv | 31 +++
 rtl/uart_frame_scheduler.sv | 88 ++++++++
 tb/tb_uart_frame_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared states and defaults for the framed-UART sender scheduler.
package uart_sched_pkg;
  localparam int DEF_CNT_W = 3;
  localparam int DEF_TO_W = 24;
  localparam logic [23:0] DEF_TIMEOUT = 24'd8_000_000;
  localparam int FRAME_LEN = 1032;
  typedef enum logic [2:0] {IDLE, ARB, START, WAIT, DONE} state_t;
endpackage

// File: rtl/uart_frame_scheduler_req.sv
// frame_req_counter: synchronizes one frame_rdy strobe and counts pending frames.
module frame_req_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             dec,
  input  logic             err_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  logic [2:0] sr;
  logic rise, sat;
  logic [CNT_W-1:0] cnt_nxt;
  assign rise = sr[1] & ~sr[2];
  assign sat = &cnt;
  // simultaneous edge and decrement cancel out
  always_comb cnt_nxt = (rise && !dec && !sat) ? cnt + 1'b1 :
                        (!rise && dec && cnt != '0) ? cnt - 1'b1 : cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      sr <= {sr[1:0], rdy};
      cnt <= cnt_nxt;
      ovf <= (rise & sat) | (ovf & ~err_clr);
    end
endmodule

// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: round-robin grants of one UART sender to NUM_REQ frame producers,
// one full frame per grant, with a watchdog that aborts stalled frames.
module uart_frame_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CH_W = 2,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TO_W = DEF_TO_W,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(DEF_TIMEOUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       frame_rdy,
  input  logic                     send_done,
  input  logic                     err_clr,
  output logic                     send_start,
  output logic [CH_W-1:0]          send_ch,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     send_abort,
  output logic                     busy,
  output logic [NUM_REQ*CNT_W-1:0] pend_cnt,
  output logic [NUM_REQ-1:0]       ovf,
  output logic                     timeout_err
);
  state_t state, nxt;
  logic [CH_W-1:0] ptr, win;
  logic [TO_W-1:0] wd;
  logic [NUM_REQ-1:0] nz;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    frame_req_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .rst_n(rst_n),
      .rdy(frame_rdy[i]),
      .dec(state == DONE && grant[i]),
      .err_clr(err_clr),
      .cnt(pend_cnt[i*CNT_W +: CNT_W]),
      .ovf(ovf[i])
    );
    assign nz[i] = |pend_cnt[i*CNT_W +: CNT_W];
  end
  // descending scan so the nearest channel after ptr wins
  always_comb begin
    win = ptr;
    for (int k = NUM_REQ; k >= 1; k--)
      if (nz[(int'(ptr) + k) % NUM_REQ]) win = CH_W'((int'(ptr) + k) % NUM_REQ);
  end
  always_comb begin
    nxt = state;
    send_abort = 1'b0;
    case (state)
      IDLE:  nxt = (enable && |nz) ? ARB : IDLE;
      ARB:   nxt = START;
      START: nxt = WAIT;
      WAIT:
        if (send_done) nxt = DONE;
        else if (wd == TIMEOUT - 1'b1) begin
          send_abort = 1'b1;
          nxt = DONE;
        end
      default: nxt = IDLE;
    endcase
  end
  assign send_start = state == START;
  assign busy = state == START || state == WAIT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      send_ch <= '0;
      grant <= '0;
      wd <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      timeout_err <= send_abort | (timeout_err & ~err_clr);
      wd <= state == START ? '0 : state == WAIT ? wd + 1'b1 : wd;
      if (state == ARB) begin
        send_ch <= win;
        grant <= NUM_REQ'(1) << win;
      end
      if (state == DONE) begin
        ptr <= send_ch;
        grant <= '0;
      end
    end
endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb_uart_frame_scheduler: directed vectors for the round-robin UART frame scheduler.
module tb_uart_frame_scheduler;
  localparam int N = 4;
  localparam int CW = 2;
  localparam int KW = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic send_done = 1'b0;
  logic err_clr = 1'b0;
  logic [N-1:0] frame_rdy = '0;
  logic send_start, send_abort, busy, timeout_err;
  logic [CW-1:0] send_ch;
  logic [N-1:0] grant, ovf;
  logic [N*KW-1:0] pend_cnt;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  uart_frame_scheduler #(
    .NUM_REQ(N), .CH_W(CW), .CNT_W(KW), .TO_W(24), .TIMEOUT(24'd100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_rdy(frame_rdy),
    .send_done(send_done), .err_clr(err_clr), .send_start(send_start),
    .send_ch(send_ch), .grant(grant), .send_abort(send_abort), .busy(busy),
    .pend_cnt(pend_cnt), .ovf(ovf), .timeout_err(timeout_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] pend(input int ch);
    return 32'(pend_cnt[ch*KW +: KW]);
  endfunction
  task automatic wait_start();
    for (int i = 0; i < 300 && send_start !== 1'b1; i++) cyc(1);
    check("start_seen", 32'(send_start), 1);
  endtask
  task automatic serve(input int ch);
    wait_start();
    check("rr_ch", 32'(send_ch), 32'(ch));
    check("rr_grant", 32'(grant), 32'(1) << ch);
    cyc(1);
    send_done = 1'b1;
    cyc(1);
    send_done = 1'b0;
    cyc(1);
  endtask
  initial begin
    cyc(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_pend", 32'(pend_cnt), 0);
    check("rst_start", 32'(send_start), 0);
    check("rst_flags", {30'd0, timeout_err, send_abort}, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    cyc(1);
    frame_rdy[2] = 1'b1;
    cyc(2);
    check("t1_pend_early", pend(2), 0);
    cyc(1);
    check("t1_pend", pend(2), 1);
    cyc(1);
    check("t1_arb_nostart", 32'(send_start), 0);
    cyc(1);
    check("t1_start", 32'(send_start), 1);
    check("t1_ch", 32'(send_ch), 2);
    check("t1_grant", 32'(grant), 4);
    check("t1_busy", 32'(busy), 1);
    frame_rdy[2] = 1'b0;
    cyc(1);
    check("t1_start_pulse", 32'(send_start), 0);
    send_done = 1'b1;
    cyc(1);
    send_done = 1'b0;
    cyc(1);
    check("t1_pend_done", pend(2), 0);
    check("t1_grant_clr", 32'(grant), 0);
    check("t1_idle", 32'(busy), 0);
    frame_rdy[1] = 1'b1;
    cyc(3);
    frame_rdy[1] = 1'b0;
    wait_start();
    check("t2_first", 32'(send_ch), 1);
    cyc(1);
    frame_rdy = 4'b1011;
    cyc(4);
    frame_rdy = '0;
    cyc(4);
    check("t2_pend_all", 32'(pend_cnt), 32'h211);
    check("t2_busy", 32'(busy), 1);
    send_done = 1'b1;
    cyc(1);
    send_done = 1'b0;
    cyc(1);
    serve(3);
    serve(0);
    serve(1);
    check("t2_drained", 32'(pend_cnt), 0);
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      frame_rdy[0] = 1'b1;
      cyc(3);
      frame_rdy[0] = 1'b0;
      cyc(3);
    end
    check("t3_sat", pend(0), 7);
    check("t3_ovf", 32'(ovf), 1);
    check("t3_no_grant", {30'd0, busy, send_start}, 0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("t3_ovf_clr", 32'(ovf), 0);
    check("t3_cnt_kept", pend(0), 7);
    enable = 1'b1;
    cyc(1);
    check("t5_arb", 32'(send_start), 0);
    cyc(1);
    check("t5_start", 32'(send_start), 1);
    check("t5_ch", 32'(send_ch), 0);
    cyc(1);
    frame_rdy[2] = 1'b1;
    cyc(4);
    frame_rdy[2] = 1'b0;
    cyc(94);
    check("t4_no_abort_yet", 32'(send_abort), 0);
    cyc(1);
    check("t4_abort", 32'(send_abort), 1);
    cyc(1);
    check("t4_abort_pulse", 32'(send_abort), 0);
    check("t4_terr", 32'(timeout_err), 1);
    cyc(1);
    check("t4_dropped", pend(0), 6);
    wait_start();
    check("t4_next_ch", 32'(send_ch), 2);
    frame_rdy[2] = 1'b1;
    cyc(1);
    send_done = 1'b1;
    cyc(1);
    send_done = 1'b0;
    check("t6_pend_done", pend(2), 1);
    cyc(1);
    check("t6_pend_same", pend(2), 1);
    check("t6_grant_clr", 32'(grant), 0);
    frame_rdy[2] = 1'b0;
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("t4_terr_clr", 32'(timeout_err), 0);
    wait_start();
    check("t7_ch", 32'(send_ch), 0);
    cyc(1);
    rst_n = 1'b0;
    #1;
    check("t7_busy", 32'(busy), 0);
    check("t7_grant", 32'(grant), 0);
    check("t7_ch_clr", 32'(send_ch), 0);
    check("t7_pend", 32'(pend_cnt), 0);
    check("t7_flags", {29'd0, timeout_err, send_abort, send_start}, 0);
    cyc(3);
    check("t7_no_abort", 32'(send_abort), 0);
    rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
